// File: rtl/truth_table_checker_pkg.sv
// Shared types and sizes for the 4-input truth table checker.
package truth_table_checker_pkg;

   localparam int NUM_VECTORS = 16;
   localparam int VEC_W       = 4;
   localparam int CNT_W       = 5;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRIVE  = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_t;

endpackage

// File: rtl/truth_table_checker_settle_timer.sv
// Settle timer: loads a count, counts down to zero, and flags expiry
// during the last cycle of the timed window.
module tt_settle_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         expire
);

   logic [W-1:0] cnt;
   logic         run;

   // Down-counter; a load value of N gives a window of N+1 cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         run <= 1'b0;
      end else if (load) begin
         cnt <= load_val;
         run <= 1'b1;
      end else if (run) begin
         if (cnt == '0) begin
            run <= 1'b0;
         end else begin
            cnt <= cnt - 1'b1;
         end
      end
   end

   // Terminal-count compare.
   assign expire = run && (cnt == '0);

endmodule

// File: rtl/truth_table_checker.sv
// Exhaustive 4-input truth table checker.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | out of reset, waiting for start
//   DRIVE  | current vector on a..d, waiting SETTLE cycles for the DUT
//   SAMPLE | one cycle; the edge leaving it compares o with EXPECTED[idx]
//   DONE   | sweep finished, results held until start or rst
module truth_table_checker
   import truth_table_checker_pkg::*;
#(
   parameter logic [NUM_VECTORS-1:0] EXPECTED = 16'h8000,
   parameter int                     SETTLE   = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             o,
   output logic             a,
   output logic             b,
   output logic             c,
   output logic             d,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] err_count,
   output logic [VEC_W-1:0] first_fail,
   output logic             fail_valid
);

   // Timer window is load value + 1 cycles, so DRIVE lasts exactly SETTLE.
   localparam logic [VEC_W-1:0] SETTLE_LOAD = VEC_W'(SETTLE - 1);
   localparam logic [VEC_W-1:0] LAST_IDX    = VEC_W'(NUM_VECTORS - 1);

   state_t           state;
   state_t           state_next;
   logic [VEC_W-1:0] idx;
   logic             timer_load;
   logic             timer_expire;
   logic             mismatch;

   tt_settle_timer #(
      .W (VEC_W)
   ) u_settle (
      .clk      (clk),
      .rst      (rst),
      .load     (timer_load),
      .load_val (SETTLE_LOAD),
      .expire   (timer_expire)
   );

   assign mismatch = (o != EXPECTED[idx]);

   // State register; reset wins over everything, including start.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic; start is only honoured while not busy.
   always_comb begin
      state_next = state;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_next = DRIVE;
            end
         end
         DRIVE: begin
            if (timer_expire) begin
               state_next = SAMPLE;
            end
         end
         SAMPLE: begin
            if (idx == LAST_IDX) begin
               state_next = DONE;
            end else begin
               state_next = DRIVE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // State-decoded outputs and the timer load on every entry into DRIVE.
   always_comb begin
      busy       = 1'b0;
      done       = 1'b0;
      pass       = 1'b0;
      timer_load = 1'b0;
      case (state)
         DRIVE, SAMPLE: busy = 1'b1;
         DONE: begin
            done = 1'b1;
            pass = (err_count == '0);
         end
         default: ;
      endcase
      if ((state_next == DRIVE) && (state != DRIVE)) begin
         timer_load = 1'b1;
      end
   end

   // Vector index and result bookkeeping.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx        <= '0;
         err_count  <= '0;
         first_fail <= '0;
         fail_valid <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  idx        <= '0;
                  err_count  <= '0;
                  first_fail <= '0;
                  fail_valid <= 1'b0;
               end
            end
            SAMPLE: begin
               if (mismatch) begin
                  err_count <= err_count + 1'b1;
                  if (!fail_valid) begin
                     first_fail <= idx;
                     fail_valid <= 1'b1;
                  end
               end
               // idx parks at the last vector so a..d hold it in DONE.
               if (idx != LAST_IDX) begin
                  idx <= idx + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // a..d come straight from the idx register, a is the MSB.
   assign a = idx[3];
   assign b = idx[2];
   assign c = idx[1];
   assign d = idx[0];

endmodule
